// File: rtl/fp32_pkg.sv
// Shared FP32 arithmetic constants and FSM state type.
// Used by the divider and multiplier datapaths.
package fp32_pkg;
  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } state_t;
endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier (zero/inf/nan).
// Ports: x word in; is_zero, is_inf, is_nan out. Exp 0 => zero.
module fp32_classify (
  input  logic [31:0] x,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);
  logic unused_sign;

  assign unused_sign = x[31];
  assign is_zero = (x[30:23] == 8'h00);
  assign is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  assign is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
endmodule

// File: rtl/fp32_divider.sv
// Iterative radix-2 restoring FP32 divider, truncating, 26-cycle latency.
// Ports: clk, rst (sync active-low), a/b/in_valid/in_ready in side,
// q/div_by_zero/out_valid/out_ready out side.
// Macro FP_DIV_SPECIAL_EN enables special operand and range handling.
module fp32_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] q,
  output logic        div_by_zero,
  output logic        out_valid,
  input  logic        out_ready
);
  state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic signed [9:0] e_q, e_d;
  logic [24:0] r_q, r_d;
  logic [23:0] mb_q, mb_d;
  logic [24:0] qm_q, qm_d;
  logic [31:0] res_q, res_d;
  logic        dbz_q, dbz_d;

  logic        ge;
  logic [24:0] rem;
  logic [22:0] mant;
  logic signed [9:0] exp;
  logic [31:0] norm_res;
  logic        norm_dbz;

  assign ge   = r_q >= {1'b0, mb_q};
  assign rem  = ge ? (r_q - {1'b0, mb_q}) : r_q;
  assign mant = qm_q[24] ? qm_q[23:1] : qm_q[22:0];
  assign exp  = qm_q[24] ? e_q : e_q - 10'sd1;

`ifdef FP_DIV_SPECIAL_EN
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic sp_hit_q, sp_hit_d, cls_hit;
  logic sp_dbz_q, sp_dbz_d, cls_dbz;
  logic [31:0] sp_val_q, sp_val_d, cls_val;
  logic s_in;

  fp32_classify u_cls_a (
    .x(a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan)
  );
  fp32_classify u_cls_b (
    .x(b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan)
  );

  assign s_in = a[31] ^ b[31];

  always_comb begin
    cls_hit = 1'b1;
    cls_dbz = 1'b0;
    cls_val = {s_in, 31'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      cls_val = QNAN;
    else if (a_inf)
      cls_val = {s_in, POS_INF[30:0]};
    else if (b_inf || a_zero)
      cls_val = {s_in, 31'd0};
    else if (b_zero) begin
      cls_val = {s_in, POS_INF[30:0]};
      cls_dbz = 1'b1;
    end else
      cls_hit = 1'b0;
  end

  always_comb begin
    norm_res = {sign_q, exp[7:0], mant};
    norm_dbz = 1'b0;
    if (sp_hit_q) begin
      norm_res = sp_val_q;
      norm_dbz = sp_dbz_q;
    end else if (exp >= 10'sd255)
      norm_res = {sign_q, POS_INF[30:0]};
    else if (exp <= 10'sd0)
      norm_res = {sign_q, 31'd0};
  end
`else
  logic unused_exp;

  // Raw fields: exponent wraps mod 256.
  assign unused_exp = ^exp[9:8];
  assign norm_res   = {sign_q, exp[7:0], mant};
  assign norm_dbz   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    e_d     = e_q;
    r_d     = r_q;
    mb_d    = mb_q;
    qm_d    = qm_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
`ifdef FP_DIV_SPECIAL_EN
    sp_hit_d = sp_hit_q;
    sp_dbz_d = sp_dbz_q;
    sp_val_d = sp_val_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = a[31] ^ b[31];
          e_d     = $signed({2'b00, a[30:23]})
                  - $signed({2'b00, b[30:23]})
                  + $signed(10'(BIAS));
          r_d     = {2'b01, a[22:0]};
          mb_d    = {1'b1, b[22:0]};
          qm_d    = '0;
          cnt_d   = 5'd24;
          state_d = DIV;
`ifdef FP_DIV_SPECIAL_EN
          sp_hit_d = cls_hit;
          sp_dbz_d = cls_dbz;
          sp_val_d = cls_val;
`endif
        end
      end
      DIV: begin
        // Quotient bits shift in MSB-first; bit 24 lands on top.
        qm_d  = {qm_q[23:0], ge};
        r_d   = {rem[23:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0)
          state_d = NORM;
      end
      NORM: begin
        res_d   = norm_res;
        dbz_d   = norm_dbz;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      e_q     <= '0;
      r_q     <= '0;
      mb_q    <= '0;
      qm_q    <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef FP_DIV_SPECIAL_EN
      sp_hit_q <= 1'b0;
      sp_dbz_q <= 1'b0;
      sp_val_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      e_q     <= e_d;
      r_q     <= r_d;
      mb_q    <= mb_d;
      qm_q    <= qm_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
`ifdef FP_DIV_SPECIAL_EN
      sp_hit_q <= sp_hit_d;
      sp_dbz_q <= sp_dbz_d;
      sp_val_q <= sp_val_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign q           = res_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench for fp32_divider.
// Scoreboard queue of expected results, per-scenario tasks.
module tb_fp32_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid, in_ready;
  logic [31:0] q;
  logic        div_by_zero, out_valid, out_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] q;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  fp32_divider dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .div_by_zero(div_by_zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eq, input logic ed,
                        input string nm);
    int   n;
    int   lat;
    exp_t e;
    out_ready = 1'b1;
    @(negedge clk);
    a = av; b = bv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL %s accept: in_ready=%b required 1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{q: eq, dbz: ed});
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s timeout: out_valid=%b required 1", nm, out_valid);
      return;
    end
    checks++;
    if (lat != 26) begin
      failures++;
      $display("FAIL %s latency: got %0d required 26", nm, lat);
    end
    checks++;
    if (q !== e.q) begin
      failures++;
      $display("FAIL %s q: got %h required %h", nm, q, e.q);
    end
    checks++;
    if (div_by_zero !== e.dbz) begin
      failures++;
      $display("FAIL %s dbz: got %b required %b", nm, div_by_zero, e.dbz);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s retire: in_ready=%b out_valid=%b required 1/0",
               nm, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset hs: in_ready=%b out_valid=%b required 1/0",
               in_ready, out_valid);
    end
    checks++;
    if (q !== 32'h0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset out: q=%h dbz=%b required 0/0",
               q, div_by_zero);
    end
  endtask

  task automatic test_basic();
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "6div2");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, "1div3");
    run_op(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, "m7p5");
    run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, "1div1");
    run_op(32'h40400000, 32'h3FC00000, 32'h40000000, 1'b0, "3div1p5");
    run_op(32'hBF800000, 32'hBF800000, 32'h3F800000, 1'b0, "neg1");
  endtask

  task automatic test_special();
`ifdef FP_DIV_SPECIAL_EN
    run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "1div0");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, "0div0");
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, "m1div0");
    run_op(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, "infdiv");
    run_op(32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, "divinf");
    run_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, "nan");
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, "ovf");
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, "unf");
`else
    run_op(32'h3F800000, 32'h00000000, 32'h7F000000, 1'b0, "1div0");
    run_op(32'h00000000, 32'h00000000, 32'h3F800000, 1'b0, "0div0");
    run_op(32'hBF800000, 32'h00000000, 32'hFF000000, 1'b0, "m1div0");
    run_op(32'h7F800000, 32'h40000000, 32'h7F000000, 1'b0, "infdiv");
    run_op(32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, "divinf");
    run_op(32'h7F000000, 32'h00800000, 32'h3E000000, 1'b0, "ovfwrap");
    run_op(32'h00800000, 32'h7F000000, 32'h41000000, 1'b0, "unfwrap");
`endif
  endtask

  task automatic test_backpressure();
    int   n;
    exp_t e;
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    sb.push_back('{q: 32'h40400000, dbz: 1'b0});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk); n++;
    end
    e = sb.pop_front();
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL bp timeout: out_valid=%b required 1", out_valid);
      out_ready = 1'b1;
      return;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== e.q) begin
        failures++;
        $display("FAIL bp hold%0d: ov=%b ir=%b q=%h required 1/0/%h",
                 i, out_valid, in_ready, q, e.q);
      end
      in_valid = (i % 2 == 0);
      a = 32'h12345678; b = 32'h3F800000;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (q !== e.q || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp final: q=%h ov=%b required %h/1",
               q, out_valid, e.q);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp retire: in_ready=%b out_valid=%b required 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int  n;
    logic seen;
    out_ready = 1'b1;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk); n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || q !== 32'h0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort state: ir=%b q=%h ov=%b required 1/0/0",
               in_ready, q, out_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort result: out_valid seen=%b required 0", seen);
    end
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[4];
    logic [31:0] tb[4];
    logic [31:0] tq[4];
    int got;
    ta = '{32'h40C00000, 32'h3F800000, 32'hC0F00000, 32'h40400000};
    tb = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h3FC00000};
    tq = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h40000000};
    out_ready = 1'b1;
    got = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int n;
          @(negedge clk);
          a = ta[i]; b = tb[i]; in_valid = 1'b1;
          n = 0;
          while (!in_ready && n < 100) begin
            @(negedge clk); n++;
          end
          if (in_ready) sb.push_back('{q: tq[i], dbz: 1'b0});
          @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int t;
        exp_t e;
        t = 0;
        while (got < 4 && t < 400) begin
          @(negedge clk); t++;
          if (out_valid) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL b2b extra: q=%h required none", q);
            end else begin
              e = sb.pop_front();
              if (q !== e.q || div_by_zero !== e.dbz) begin
                failures++;
                $display("FAIL b2b res%0d: q=%h dbz=%b required %h/%b",
                         got, q, div_by_zero, e.q, e.dbz);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL b2b count: got %0d required 4", got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
